// File: rtl/serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - WIDTH_DEFAULT : default operand/result width
//   - state_t       : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - cnt_width()   : bit counter width, max(1, clog2(width))
// ---------------------------------------------------------------------------
package serial_add_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A one-bit operand still needs a one-bit counter, hence the floor of 1.
    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle for serial_add_ctrl.
//   start     : request one addition (requester -> adder)
//   a_in/b_in : operands, captured on the accepted start
//   busy      : adder is in RUN or DONE
//   done      : one-cycle pulse, result valid
//   sum_out   : A+B mod 2^WIDTH
//   carry_out : carry out of bit WIDTH-1
// Modports: master = requester side, slave = adder side.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    modport master (
        output start, a_in, b_in,
        input  busy, done, sum_out, carry_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, sum_out, carry_out
    );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// ---------------------------------------------------------------------------
// serial_fa
// Combinational one-bit full adder built from two half-adder stages and an
// OR that merges their carries.
//   a, b, cin : addend bits and carry in
//   sum       : a ^ b ^ cin
//   cout      : carry out
// ---------------------------------------------------------------------------
module serial_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_ha0_sum;
    logic w_ha0_carry;
    logic w_ha1_carry;

    // First half adder: a + b
    assign w_ha0_sum   = a ^ b;
    assign w_ha0_carry = a & b;

    // Second half adder: partial sum + cin
    assign sum         = w_ha0_sum ^ cin;
    assign w_ha1_carry = w_ha0_sum & cin;

    assign cout        = w_ha0_carry | w_ha1_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller. An accepted start captures A and B, then one
// full-adder cell processes one bit per RUN cycle, LSB first, for WIDTH
// cycles. The completed sum and carry are registered onto the outputs as the
// FSM enters DONE and are held there until the next operation completes.
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : serial_add_ctrl_if.slave (start, a_in, b_in, busy, done,
//          sum_out, carry_out)
// Latency: start sampled at edge N -> done sampled high at edge N+WIDTH+1.
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("serial_add_ctrl: WIDTH must be in 1..32");
    end

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_c;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    logic               w_sum;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    serial_fa u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_c),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Sum bits enter at the MSB and migrate down, so after WIDTH shifts
    // bit 0 of the result sits at the LSB. Written as shift-then-set so the
    // same expression also holds for WIDTH=1.
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a_in;
                        r_b     <= bus.b_in;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_c     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_c   <= w_cout;
                    if (w_last) begin
                        // Counter parks at WIDTH-1 rather than wrapping.
                        r_sum   <= w_res_next;
                        r_carry <= w_cout;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum_out   = r_sum;
    assign bus.carry_out = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Drives one 8-bit operation starting from IDLE (#1 after an edge).
    // lat counts rising edges from the accepting edge (1) until done is seen.
    // Returns after one further edge, sampling the post-DONE state.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit repulse,
                       output int lat, output logic [7:0] s, output logic c,
                       output bit busy_ok, output bit held_ok,
                       output logic post_done, output logic post_busy);
        logic [7:0] prev_s;
        logic       prev_c;
        prev_s  = bus8.sum_out;
        prev_c  = bus8.carry_out;
        lat     = 0;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        bus8.start = 1'b1;
        bus8.a_in  = a;
        bus8.b_in  = b;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) bus8.start = 1'b0;
            if (repulse && cyc == 3) begin
                bus8.start = 1'b1;
                bus8.a_in  = 8'hAA;
                bus8.b_in  = 8'h55;
            end
            if (repulse && cyc == 4) bus8.start = 1'b0;
            if (bus8.done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (bus8.busy !== 1'b1) busy_ok = 1'b0;
            if (bus8.sum_out !== prev_s || bus8.carry_out !== prev_c) held_ok = 1'b0;
        end
        s = bus8.sum_out;
        c = bus8.carry_out;
        @(posedge clk); #1;
        post_done = bus8.done;
        post_busy = bus8.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a_in = 8'h12; bus8.b_in = 8'h34;
        bus1.start = 1'b1; bus1.a_in = 1'b1;  bus1.b_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy8: got %b want 0", bus8.busy); end
        total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL reset_done8: got %b want 0", bus8.done); end
        total++; if (bus8.sum_out !== 8'h00) begin bad++; $display("FAIL reset_sum8: got %h want 00", bus8.sum_out); end
        total++; if (bus8.carry_out !== 1'b0) begin bad++; $display("FAIL reset_carry8: got %b want 0", bus8.carry_out); end
        total++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin bad++; $display("FAIL reset_ctl1: got busy=%b done=%b want 0 0", bus1.busy, bus1.done); end
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        // start was high during reset only; nothing may have been accepted
        total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored: got busy=%b want 0", bus8.busy); end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] s; logic c; bit bok, hok; logic pd, pb;
        op8(8'h03, 8'h05, 1'b0, lat, s, c, bok, hok, pd, pb);
        total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
        total++; if (s !== 8'h08) begin bad++; $display("FAIL basic_sum: got %h want 08", s); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL basic_carry: got %b want 0", c); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy_run: got %b want 1", bok); end
        total++; if (hok !== 1'b1) begin bad++; $display("FAIL basic_held_in_run: got %b want 1", hok); end
        total++; if (pd !== 1'b0 || pb !== 1'b0) begin bad++; $display("FAIL basic_post: got done=%b busy=%b want 0 0", pd, pb); end
        total++; if (bus8.sum_out !== 8'h08) begin bad++; $display("FAIL basic_sum_hold: got %h want 08", bus8.sum_out); end
    endtask

    task automatic test_carry_b2b();
        int lat; logic [7:0] s; logic c; bit bok, hok; logic pd, pb;
        op8(8'hFF, 8'h01, 1'b0, lat, s, c, bok, hok, pd, pb);
        total++; if (s !== 8'h00 || c !== 1'b1) begin bad++; $display("FAIL carry_ff01: got c=%b s=%h want 1 00", c, s); end
        total++; if (lat !== 9) begin bad++; $display("FAIL carry_ff01_latency: got %0d want 9", lat); end
        // Back-to-back: op8 returns in the IDLE cycle after DONE
        op8(8'hFF, 8'hFF, 1'b0, lat, s, c, bok, hok, pd, pb);
        total++; if (s !== 8'hFE || c !== 1'b1) begin bad++; $display("FAIL b2b_ffff: got c=%b s=%h want 1 fe", c, s); end
        total++; if (lat !== 9) begin bad++; $display("FAIL b2b_latency: got %0d want 9", lat); end
        total++; if (hok !== 1'b1) begin bad++; $display("FAIL b2b_held_in_run: got %b want 1", hok); end
    endtask

    task automatic test_mid_run_start();
        int lat; logic [7:0] s; logic c; bit bok, hok; logic pd, pb;
        int extra;
        bit stable;
        op8(8'h10, 8'h20, 1'b1, lat, s, c, bok, hok, pd, pb);
        total++; if (s !== 8'h30 || c !== 1'b0) begin bad++; $display("FAIL midrun_sum: got c=%b s=%h want 0 30", c, s); end
        total++; if (lat !== 9) begin bad++; $display("FAIL midrun_latency: got %0d want 9", lat); end
        extra  = 0;
        stable = 1'b1;
        if (pd === 1'b1) extra++;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus8.done !== 1'b0) extra++;
            if (bus8.busy !== 1'b0) extra++;
            if (bus8.sum_out !== 8'h30) stable = 1'b0;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL midrun_single_done: got %0d extra activity want 0", extra); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL midrun_sum_stable: got %b want 1", stable); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [7:0] s; logic c; bit bok, hok; logic pd, pb;
        bus8.start = 1'b1; bus8.a_in = 8'hFF; bus8.b_in = 8'hFF;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus8.busy !== 1'b1) begin bad++; $display("FAIL rstrun_busy_before: got %b want 1", bus8.busy); end
        rst = 1'b1;
        #1;
        total++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin bad++; $display("FAIL rstrun_ctl: got busy=%b done=%b want 0 0", bus8.busy, bus8.done); end
        total++; if (bus8.sum_out !== 8'h00 || bus8.carry_out !== 1'b0) begin bad++; $display("FAIL rstrun_result: got c=%b s=%h want 0 00", bus8.carry_out, bus8.sum_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        op8(8'h01, 8'h01, 1'b0, lat, s, c, bok, hok, pd, pb);
        total++; if (s !== 8'h02 || c !== 1'b0) begin bad++; $display("FAIL rstrun_next_sum: got c=%b s=%h want 0 02", c, s); end
        total++; if (lat !== 9) begin bad++; $display("FAIL rstrun_next_latency: got %0d want 9", lat); end
    endtask

    task automatic test_width1();
        logic [1:0] exp_tab [4];
        int lat;
        exp_tab[0] = 2'b00; exp_tab[1] = 2'b01; exp_tab[2] = 2'b01; exp_tab[3] = 2'b10;
        for (int k = 0; k < 4; k++) begin
            bus1.start = 1'b1;
            bus1.a_in  = k[1];
            bus1.b_in  = k[0];
            lat = 0;
            for (int cyc = 1; cyc <= 10; cyc++) begin
                @(posedge clk); #1;
                if (cyc == 1) bus1.start = 1'b0;
                if (bus1.done === 1'b1) begin
                    lat = cyc;
                    break;
                end
            end
            total++; if ({bus1.carry_out, bus1.sum_out} !== exp_tab[k]) begin bad++; $display("FAIL w1_result_%0d: got %b want %b", k, {bus1.carry_out, bus1.sum_out}, exp_tab[k]); end
            total++; if (lat !== 2) begin bad++; $display("FAIL w1_latency_%0d: got %0d want 2", k, lat); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0;
        test_reset();
        test_basic();
        test_carry_b2b();
        test_mid_run_start();
        test_reset_mid_run();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and result width in bits; legal range 1..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request one addition; sampled only in IDLE.
REQ-005 SHALL have port: a_in  input  WIDTH  operand A; captured on the accepted start.
REQ-006 SHALL have port: b_in  input  WIDTH  operand B; captured on the accepted start.
REQ-007 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: sum_out  output  WIDTH  result A+B mod 2^WIDTH.
REQ-010 SHALL have port: carry_out  output  1  carry out of bit WIDTH-1.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL, in IDLE with start=1, load A and B shift registers, clear the bit counter, clear the carry flop, and enter RUN next cycle.
REQ-013 SHALL, each RUN cycle, add LSB(A), LSB(B) and the carry flop in one full-adder cell, shift A and B right, shift the sum bit into the result MSB, register the cell carry, and increment the counter.
REQ-014 SHALL leave RUN for DONE after exactly WIDTH RUN cycles (counter==WIDTH-1 at the transition), the result register then holding bit 0 at LSB.
REQ-015 SHALL, in DONE, assert done for exactly one cycle, drive sum_out/carry_out from the completed result, and return to IDLE next cycle.
REQ-016 SHALL give fixed latency: start sampled at edge N -> done high during cycle N+WIDTH+1.
REQ-017 SHALL ignore start in RUN and DONE; no queuing, no operand change mid-operation.
REQ-018 SHALL hold sum_out and carry_out stable from DONE until the next accepted start completes; not updated during RUN.
REQ-019 SHALL accept a start asserted in the IDLE cycle directly following DONE (back-to-back ops, one idle cycle).
REQ-020 SHALL, for WIDTH=1, spend exactly one RUN cycle.
REQ-021 SHALL size the counter to max(1, clog2(WIDTH)) bits; no wrap beyond WIDTH-1.

Reset
REQ-022 SHALL, on rst=1 (any state, including mid-RUN), immediately enter IDLE and clear busy=0, done=0, sum_out=0, carry_out=0, shift registers, counter and carry flop.
REQ-023 SHALL ignore start while rst=1; the first accepted start is the first edge with rst=0 and start=1.

Structure
REQ-024 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default in shared package serial_add_pkg.
REQ-025 SHALL instantiate one sub-module, serial_fa: combinational full-adder cell (two half-adder cells plus OR for carry), ports a, b, cin, sum, cout.
REQ-026 SHALL contain no other combinational path from inputs to outputs; all outputs registered.

Verification
REQ-027 SHALL cover: WIDTH=8, start with A=0x03, B=0x05 -> done 9 cycles after start, sum_out=0x08, carry_out=0.
REQ-028 SHALL cover: A=0xFF, B=0x01 -> sum_out=0x00, carry_out=1; then A=0xFF, B=0xFF back-to-back -> sum_out=0xFE, carry_out=1.
REQ-029 SHALL cover: start pulsed with A=0x10, B=0x20, re-pulsed mid-RUN with A=0xAA, B=0x55 -> single done, sum_out=0x30, carry_out=0.
REQ-030 SHALL cover: rst asserted during RUN cycle 4 -> busy, done, sum_out, carry_out all 0 same cycle; next start A=0x01, B=0x01 -> sum_out=0x02 with normal latency.
REQ-031 SHALL cover: WIDTH=1 build, all four {A,B} combinations -> {carry_out,sum_out} = 00, 01, 01, 10, done 2 cycles after each start.
